mem_access_ctrl: RTL and testbench

- Memory-stage controller sitting between the ALU output (memory-operation fields) and the single-port, word-wide data RAM (cRamDepth words of cXLEN bits).
- Sequences each load or store onto the RAM and holds the pipeline with `stall` while an access is in flight.
- Applies RV32I byte lanes to stores and sign/zero-extension to loads, then issues the load result as a register-write operation (dv/addr/data).

---
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: sequences one load or store at a time onto a single-port word RAM,
// lane-aligns store data and extends load data into a register-write pulse.
module mem_access_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned RAM_LAT   = 1,
  localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [XLEN-1:0] memAddr,
  input  logic [XLEN-1:0] memData,
  input  logic [2:0]      memOpType,
  input  logic [4:0]      memRdAddr,
  output logic            stall,
  output logic            ramEn,
  output logic [3:0]      ramWe,
  output logic [AW-1:0]   ramAddr,
  output logic [XLEN-1:0] ramWdata,
  input  logic [XLEN-1:0] ramRdata,
  output logic            wbDv,
  output logic [4:0]      wbAddr,
  output logic [XLEN-1:0] wbData,
  output logic            memErr
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StWb} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_load_q, is_load_d;
  logic            ram_en_q, ram_en_d;
  logic [3:0]      ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [XLEN-1:0] ram_wdata_q, ram_wdata_d;
  logic            wb_dv_q, wb_dv_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mem_err_q, mem_err_d;

  logic [XLEN-1:0] word_idx;
  logic            op_bad, misalign, out_of_range, accept, reject;
  logic [XLEN-1:0] lane_data, load_val;

  assign word_idx     = memAddr >> 2;
  assign out_of_range = word_idx >= XLEN'(RAM_DEPTH);
  assign op_bad       = (memOpType == 3'b011) || (memOpType[2:1] == 2'b11) ||
                        (memWrite && memOpType[2]);
  assign misalign     = ((memOpType[1:0] == 2'b01) && memAddr[0]) ||
                        ((memOpType[1:0] == 2'b10) && (memAddr[1:0] != 2'b00));
  assign accept       = (state_q == StIdle) && (memRead ^ memWrite) &&
                        !op_bad && !misalign && !out_of_range;
  assign reject       = (state_q == StIdle) && (memRead || memWrite) && !accept;

  // Halfword loads are aligned, so shifting by the byte offset puts the lane at bit 0.
  assign lane_data = ramRdata >> {lane_q, 3'b000};

  always_comb begin
    load_val = ramRdata;
    case (op_q)
      3'b000:  load_val = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_val = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_data[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_data[15:0]};
      default: load_val = ramRdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    op_d        = op_q;
    rd_d        = rd_q;
    is_load_d   = is_load_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wb_dv_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_err_d   = reject;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lane_d     = memAddr[1:0];
          op_d       = memOpType;
          rd_d       = memRdAddr;
          is_load_d  = memRead;
          ram_en_d   = 1'b1;
          ram_addr_d = memAddr[AW+1:2];
          if (memWrite) begin
            unique case (memOpType[1:0])
              2'b00: begin
                ram_we_d    = 4'b0001 << memAddr[1:0];
                ram_wdata_d = {(XLEN/8){memData[7:0]}};
              end
              2'b01: begin
                ram_we_d    = 4'b0011 << memAddr[1:0];
                ram_wdata_d = {(XLEN/16){memData[15:0]}};
              end
              default: begin
                ram_we_d    = 4'b1111;
                ram_wdata_d = memData;
              end
            endcase
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (is_load_q) begin
          cnt_d   = 3'(RAM_LAT - 1);
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          wb_dv_d   = (rd_q != 5'd0);
          wb_addr_d = rd_q;
          wb_data_d = load_val;
          state_d   = StWb;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lane_q      <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wb_dv_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      is_load_q   <= is_load_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wb_dv_q     <= wb_dv_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall    = (state_q != StIdle);
  assign ramEn    = ram_en_q;
  assign ramWe    = ram_we_q;
  assign ramAddr  = ram_addr_q;
  assign ramWdata = ram_wdata_q;
  assign wbDv     = wb_dv_q;
  assign wbAddr   = wb_addr_q;
  assign wbData   = wb_data_q;
  assign memErr   = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (RAM latency 1 and 3), each on a behavioural RAM,
// checked against a byte-addressed reference memory.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_data  [2];
  logic [2:0]  op_type   [2];
  logic [4:0]  rd_addr   [2];
  logic        stall     [2];
  logic        ram_en    [2];
  logic [3:0]  ram_we    [2];
  logic [9:0]  ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic        wb_dv     [2];
  logic [4:0]  wb_addr   [2];
  logic [31:0] wb_data   [2];
  logic        mem_err   [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [2][4096];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    logic [31:0] ram  [1024];
    logic [31:0] pipe [Lat];
    logic [31:0] rdata;

    mem_access_ctrl #(.XLEN(32), .RAM_DEPTH(1024), .RAM_LAT(Lat)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .memRead  (mem_read[g]),
      .memWrite (mem_write[g]),
      .memAddr  (mem_addr[g]),
      .memData  (mem_data[g]),
      .memOpType(op_type[g]),
      .memRdAddr(rd_addr[g]),
      .stall    (stall[g]),
      .ramEn    (ram_en[g]),
      .ramWe    (ram_we[g]),
      .ramAddr  (ram_addr[g]),
      .ramWdata (ram_wdata[g]),
      .ramRdata (rdata),
      .wbDv     (wb_dv[g]),
      .wbAddr   (wb_addr[g]),
      .wbData   (wb_data[g]),
      .memErr   (mem_err[g])
    );

    initial for (int w = 0; w < 1024; w++) ram[w] = 32'h0;

    // Read data is X except exactly Lat cycles after an enabled access.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) ram[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        pipe[0] <= ram[ram_addr[g]];
      end else begin
        pipe[0] <= 32'hxxxxxxxx;
      end
      for (int k = 1; k < Lat; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata = pipe[Lat-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (stall[i] !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) chk("idle_timeout", {31'd0, stall[i]}, 32'd0);
  endtask

  task automatic txn(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [2:0] op, input logic [4:0] rda);
    int nb, lat;
    bit err;
    logic [3:0]  we;
    logic [31:0] wd, ev;
    lat = (i == 0) ? 1 : 3;
    nb  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    err = (rd && wr) || op == 3'd3 || op >= 3'd6 || (wr && op[2]) ||
          (addr % nb != 0) || (addr / 4 >= 1024);
    wait_idle(i);
    mem_read[i] = rd; mem_write[i] = wr; mem_addr[i] = addr;
    mem_data[i] = data; op_type[i] = op; rd_addr[i] = rda;
    @(negedge clk);
    mem_read[i] = 1'b0; mem_write[i] = 1'b0;
    chk("mem_err", {31'd0, mem_err[i]}, {31'd0, err});
    if (err) begin
      chk("err_ram_en", {31'd0, ram_en[i]}, 32'd0);
      chk("err_stall", {31'd0, stall[i]}, 32'd0);
      return;
    end
    chk("acc_ram_en", {31'd0, ram_en[i]}, 32'd1);
    chk("acc_stall", {31'd0, stall[i]}, 32'd1);
    chk("acc_ram_addr", {22'd0, ram_addr[i]}, addr / 4);
    if (wr) begin
      we = '0;
      for (int k = 0; k < nb; k++) we[(addr + k) % 4] = 1'b1;
      for (int j = 0; j < 4; j++) wd[8*j +: 8] = data[8*(j % nb) +: 8];
      for (int k = 0; k < nb; k++) ref_mem[i][addr + k] = data[8*k +: 8];
      chk("st_we", {28'd0, ram_we[i]}, {28'd0, we});
      chk("st_wdata", ram_wdata[i], wd);
      @(negedge clk);
      chk("st_done_stall", {31'd0, stall[i]}, 32'd0);
      chk("st_done_we", {28'd0, ram_we[i]}, 32'd0);
    end else begin
      ev = '0;
      for (int k = 0; k < nb; k++) ev[8*k +: 8] = ref_mem[i][addr + k];
      if (op == 3'b000 && ev[7])  ev[31:8]  = '1;
      if (op == 3'b001 && ev[15]) ev[31:16] = '1;
      chk("ld_we", {28'd0, ram_we[i]}, 32'd0);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        chk("wait_stall", {31'd0, stall[i]}, 32'd1);
        chk("wait_ram_en", {31'd0, ram_en[i]}, 32'd0);
        chk("wait_wb_dv", {31'd0, wb_dv[i]}, 32'd0);
      end
      @(negedge clk);
      chk("wb_dv", {31'd0, wb_dv[i]}, {31'd0, rda != 5'd0});
      chk("wb_stall", {31'd0, stall[i]}, 32'd1);
      if (rda != 5'd0) begin
        chk("wb_addr", {27'd0, wb_addr[i]}, {27'd0, rda});
        chk("wb_data", wb_data[i], ev);
      end
      @(negedge clk);
      chk("ld_done_stall", {31'd0, stall[i]}, 32'd0);
      chk("ld_done_wb_dv", {31'd0, wb_dv[i]}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input int i);
    chk("rst_stall", {31'd0, stall[i]}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en[i]}, 32'd0);
    chk("rst_ram_we", {28'd0, ram_we[i]}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr[i]}, 32'd0);
    chk("rst_ram_wdata", ram_wdata[i], 32'd0);
    chk("rst_wb_dv", {31'd0, wb_dv[i]}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr[i]}, 32'd0);
    chk("rst_wb_data", wb_data[i], 32'd0);
    chk("rst_mem_err", {31'd0, mem_err[i]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  op;
    int r;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; mem_read[i] = 1'b0; mem_write[i] = 1'b0; mem_addr[i] = '0;
      mem_data[i] = '0; op_type[i] = '0; rd_addr[i] = '0;
      for (int b = 0; b < 4096; b++) ref_mem[i][b] = 8'h00;
    end
    @(negedge clk); @(negedge clk);
    chk_all_zero(0);
    chk_all_zero(1);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Directed stores and extending loads on the latency-1 instance.
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 5'd0);
    txn(0, 0, 1, 32'h13, 32'h000000A5, 3'b000, 5'd0);
    txn(0, 0, 1, 32'h10, 32'h80F07F01, 3'b010, 5'd0);
    txn(0, 1, 0, 32'h11, 32'h0, 3'b000, 5'd5);
    chk("lb_value", wb_data[0], 32'h0000007F);
    txn(0, 1, 0, 32'h12, 32'h0, 3'b001, 5'd6);
    chk("lh_value", wb_data[0], 32'hFFFF80F0);
    txn(0, 1, 0, 32'h12, 32'h0, 3'b101, 5'd7);
    chk("lhu_value", wb_data[0], 32'h000080F0);
    txn(0, 1, 0, 32'h6, 32'h0, 3'b010, 5'd1);
    txn(0, 0, 1, 32'h1000, 32'h1234, 3'b010, 5'd0);
    txn(0, 1, 1, 32'h10, 32'h1234, 3'b010, 5'd2);
    txn(0, 0, 1, 32'h10, 32'h1234, 3'b100, 5'd0);

    // Reset while a load sits in WAIT.
    wait_idle(0);
    mem_read[0] = 1'b1; mem_addr[0] = 32'h10; op_type[0] = 3'b010; rd_addr[0] = 5'd9;
    @(negedge clk);
    mem_read[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", {31'd0, stall[0]}, 32'd1);
    rst[0] = 1'b1;
    #1;
    chk_all_zero(0);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_wb_dv", {31'd0, wb_dv[0]}, 32'd0);
    end

    // Latency-3 instance: writeback to x0, then a store straight after.
    txn(1, 1, 0, 32'h0, 32'h0, 3'b010, 5'd0);
    txn(1, 0, 1, 32'h20, 32'hC3A5_0F81, 3'b010, 5'd0);
    txn(1, 1, 0, 32'h23, 32'h0, 3'b000, 5'd3);
    chk("lat3_lb", wb_data[1], 32'hFFFFFFC3);

    // Randomised traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 80; n++) begin
        a = ($urandom_range(0, 11) == 0) ? 32'h1000 + $urandom_range(0, 63)
                                          : 32'($urandom_range(0, 63));
        d = $urandom;
        if ($urandom_range(0, 9) == 0) begin
          r = $urandom_range(0, 2);
          op = (r == 0) ? 3'b011 : (r == 1) ? 3'b110 : 3'b111;
        end else begin
          r = $urandom_range(0, 4);
          op = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b010 :
               (r == 3) ? 3'b100 : 3'b101;
        end
        r = $urandom_range(0, 9);
        txn(i, r < 5, r == 0 || r >= 5, a, d, op, 5'($urandom_range(0, 31)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
